// File: rtl/ex_muldiv_pkg.sv
// ex_muldiv_pkg: shared constants and helpers for the EX-stage multiply/divide unit.
//   - ALU opcodes for the eight HI/LO-producing operations
//   - Stall encodings, word/double-word types
//   - FSM state encodings (MD_*)
//   - Small opcode classification functions used by the control FSM
package ex_muldiv_pkg;

  typedef logic [7:0]  aluop_t;   // AluOpBus
  typedef logic [31:0] reg_t;     // RegBus
  typedef logic [63:0] dreg_t;    // DoubleRegBus

  localparam aluop_t EXE_NOP_OP   = 8'b0000_0000;
  localparam aluop_t EXE_MULT_OP  = 8'b0001_1000;
  localparam aluop_t EXE_MULTU_OP = 8'b0001_1001;
  localparam aluop_t EXE_DIV_OP   = 8'b0001_1010;
  localparam aluop_t EXE_DIVU_OP  = 8'b0001_1011;
  localparam aluop_t EXE_MADD_OP  = 8'b1010_0110;
  localparam aluop_t EXE_MADDU_OP = 8'b1010_1000;
  localparam aluop_t EXE_MSUB_OP  = 8'b1010_1010;
  localparam aluop_t EXE_MSUBU_OP = 8'b1010_1011;

  localparam logic  STOP      = 1'b1;
  localparam logic  NO_STOP   = 1'b0;
  localparam reg_t  ZERO_WORD = 32'h0000_0000;

  localparam logic [2:0] MD_IDLE = 3'd0;
  localparam logic [2:0] MD_MUL  = 3'd1;
  localparam logic [2:0] MD_ACC  = 3'd2;
  localparam logic [2:0] MD_DIV  = 3'd3;
  localparam logic [2:0] MD_DONE = 3'd4;

  function automatic logic is_div_op(input aluop_t op);
    return op inside {EXE_DIV_OP, EXE_DIVU_OP};
  endfunction

  // madd/msub family: product is folded into the forwarded HI/LO
  function automatic logic is_acc_op(input aluop_t op);
    return op inside {EXE_MADD_OP, EXE_MADDU_OP, EXE_MSUB_OP, EXE_MSUBU_OP};
  endfunction

  function automatic logic is_sub_op(input aluop_t op);
    return op inside {EXE_MSUB_OP, EXE_MSUBU_OP};
  endfunction

  function automatic logic is_md_op(input aluop_t op);
    return op inside {EXE_MULT_OP, EXE_MULTU_OP} || is_acc_op(op) || is_div_op(op);
  endfunction

  function automatic logic is_signed_op(input aluop_t op);
    return op inside {EXE_MULT_OP, EXE_MADD_OP, EXE_MSUB_OP, EXE_DIV_OP};
  endfunction

endpackage

// File: rtl/ex_muldiv_if.sv
// ex_muldiv_if: ID/EX-side connection of the multiply/divide unit.
//   stall[5:0]   pipeline stall vector (bit 3 = EX held)
//   flush        cancel in-flight operation
//   aluop_i, reg1_i, reg2_i   operation and operands from ID/EX
//   hi_i, lo_i   forwarded HI/LO
//   stallreq_o   stall request toward the pipeline controller
//   whilo_o, hi_o, lo_o       HI/LO write toward EX/MEM
// master = EX stage side, slave = the multiply/divide unit.
interface ex_muldiv_if;
  import ex_muldiv_pkg::*;

  logic [5:0] stall;
  logic       flush;
  aluop_t     aluop_i;
  reg_t       reg1_i;
  reg_t       reg2_i;
  reg_t       hi_i;
  reg_t       lo_i;
  logic       stallreq_o;
  logic       whilo_o;
  reg_t       hi_o;
  reg_t       lo_o;

  modport master (
    output stall, flush, aluop_i, reg1_i, reg2_i, hi_i, lo_i,
    input  stallreq_o, whilo_o, hi_o, lo_o
  );

  modport slave (
    input  stall, flush, aluop_i, reg1_i, reg2_i, hi_i, lo_i,
    output stallreq_o, whilo_o, hi_o, lo_o
  );
endinterface

// File: rtl/ex_muldiv_div_core.sv
// ex_muldiv_div_core: restoring divider, one quotient bit per cycle.
//   clk, rst         clock, asynchronous active-low reset
//   start            load operands (cycle 0 edge); iterations follow on cycles 1..DIV_ITERS
//   cancel           abandon the current division
//   sign             treat operands as two's complement
//   dividend, divisor operands (divisor must be non-zero)
//   done             high during the last iteration cycle
//   quotient, remainder  final, sign-corrected results; valid while done is high
module ex_muldiv_div_core
  import ex_muldiv_pkg::*;
#(
  parameter int DIV_ITERS = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic cancel,
  input  logic sign,
  input  reg_t dividend,
  input  reg_t divisor,
  output logic done,
  output reg_t quotient,
  output reg_t remainder
);

  localparam int CW = $clog2(DIV_ITERS);

  logic          busy_reg;
  logic [CW-1:0] cnt_reg;
  reg_t          quo_reg, rem_reg, dvs_reg;
  logic          neg_q_reg, neg_r_reg;

  reg_t          a_mag, b_mag, quo_next, rem_next;
  logic [32:0]   shifted, diff;
  logic          fits;

  // Division runs on magnitudes; signs are reapplied on the way out.
  assign a_mag = (sign && dividend[31]) ? (~dividend + 32'd1) : dividend;
  assign b_mag = (sign && divisor[31])  ? (~divisor + 32'd1)  : divisor;

  // quo_reg doubles as the dividend shift register: its MSB feeds the
  // partial remainder while the new quotient bit enters at the LSB.
  assign shifted  = {rem_reg, quo_reg[31]};
  assign diff     = shifted - {1'b0, dvs_reg};
  assign fits     = ~diff[32];
  assign rem_next = fits ? diff[31:0] : shifted[31:0];
  assign quo_next = {quo_reg[30:0], fits};

  assign done      = busy_reg && (cnt_reg == CW'(DIV_ITERS - 1));
  assign quotient  = neg_q_reg ? (~quo_next + 32'd1) : quo_next;
  assign remainder = neg_r_reg ? (~rem_next + 32'd1) : rem_next;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_reg  <= 1'b0;
      cnt_reg   <= '0;
      quo_reg   <= ZERO_WORD;
      rem_reg   <= ZERO_WORD;
      dvs_reg   <= ZERO_WORD;
      neg_q_reg <= 1'b0;
      neg_r_reg <= 1'b0;
    end else if (cancel) begin
      busy_reg <= 1'b0;
      cnt_reg  <= '0;
    end else if (start) begin
      busy_reg  <= 1'b1;
      cnt_reg   <= '0;
      quo_reg   <= a_mag;
      rem_reg   <= ZERO_WORD;
      dvs_reg   <= b_mag;
      neg_q_reg <= sign && (dividend[31] ^ divisor[31]);
      neg_r_reg <= sign && dividend[31];
    end else if (busy_reg) begin
      quo_reg <= quo_next;
      rem_reg <= rem_next;
      cnt_reg <= cnt_reg + 1'b1;
      if (done) busy_reg <= 1'b0;
    end
  end

endmodule

// File: rtl/ex_muldiv.sv
// ex_muldiv: multi-cycle MULT/MULTU/MADD(U)/MSUB(U)/DIV(U) unit in the EX stage.
//   clk   pipeline clock
//   rst   asynchronous active-low reset
//   md    ex_muldiv_if.slave: stall/flush, ID/EX operation and operands,
//         forwarded HI/LO in; stall request and HI/LO write out.
// Latency (cycle 0 = op first presented): mult 2, madd/msub 3,
// divide by zero 1, divide DIV_ITERS+1. Result is offered in DONE until
// stall[3] releases.
module ex_muldiv
  import ex_muldiv_pkg::*;
#(
  parameter int DIV_ITERS = 32
) (
  input  logic clk,
  input  logic rst,
  ex_muldiv_if.slave md
);

  logic [2:0] state_reg, state_next;
  aluop_t     op_reg;
  reg_t       opa_reg, opb_reg;
  dreg_t      prod_reg;
  reg_t       hi_reg, lo_reg;

  logic       start_op, div_start, div_done, div_signed;
  reg_t       div_quo, div_rem;
  dreg_t      smul, umul, mul_full, acc_full;

  assign start_op   = (state_reg == MD_IDLE) && is_md_op(md.aluop_i) && !md.flush;
  assign div_start  = start_op && is_div_op(md.aluop_i) && (md.reg2_i != ZERO_WORD);
  assign div_signed = is_signed_op(md.aluop_i);

  ex_muldiv_div_core #(.DIV_ITERS(DIV_ITERS)) u_div_core (
    .clk       (clk),
    .rst       (rst),
    .start     (div_start),
    .cancel    (md.flush),
    .sign      (div_signed),
    .dividend  (md.reg1_i),
    .divisor   (md.reg2_i),
    .done      (div_done),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  assign smul     = $signed({{32{opa_reg[31]}}, opa_reg}) * $signed({{32{opb_reg[31]}}, opb_reg});
  assign umul     = {32'd0, opa_reg} * {32'd0, opb_reg};
  assign mul_full = is_signed_op(op_reg) ? smul : umul;
  // HI/LO are sampled in the ACC cycle so a value forwarded late still counts.
  assign acc_full = is_sub_op(op_reg) ? ({md.hi_i, md.lo_i} - prod_reg)
                                      : ({md.hi_i, md.lo_i} + prod_reg);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      MD_IDLE: begin
        if (start_op) begin
          if (!is_div_op(md.aluop_i))        state_next = MD_MUL;
          else if (md.reg2_i == ZERO_WORD)   state_next = MD_DONE;
          else                               state_next = MD_DIV;
        end
      end
      MD_MUL:  state_next = is_acc_op(op_reg) ? MD_ACC : MD_DONE;
      MD_ACC:  state_next = MD_DONE;
      MD_DIV:  if (div_done) state_next = MD_DONE;
      MD_DONE: if (md.stall[3] == NO_STOP) state_next = MD_IDLE;
      default: state_next = MD_IDLE;
    endcase
    if (md.flush) state_next = MD_IDLE;
  end

  // rst gates the combinational request so it drops the instant reset asserts.
  assign md.stallreq_o = rst && !md.flush &&
                         (start_op || (state_reg == MD_MUL) ||
                          (state_reg == MD_ACC) || (state_reg == MD_DIV));
  assign md.whilo_o    = !md.flush && (state_reg == MD_DONE);
  assign md.hi_o       = hi_reg;
  assign md.lo_o       = lo_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= MD_IDLE;
      op_reg    <= EXE_NOP_OP;
      opa_reg   <= ZERO_WORD;
      opb_reg   <= ZERO_WORD;
      prod_reg  <= '0;
      hi_reg    <= ZERO_WORD;
      lo_reg    <= ZERO_WORD;
    end else begin
      state_reg <= state_next;
      if (!md.flush) begin
        case (state_reg)
          MD_IDLE: begin
            if (start_op) begin
              op_reg  <= md.aluop_i;
              opa_reg <= md.reg1_i;
              opb_reg <= md.reg2_i;
              if (is_div_op(md.aluop_i) && (md.reg2_i == ZERO_WORD)) begin
                hi_reg <= ZERO_WORD;
                lo_reg <= ZERO_WORD;
              end
            end
          end
          MD_MUL: begin
            prod_reg <= mul_full;
            if (!is_acc_op(op_reg)) {hi_reg, lo_reg} <= mul_full;
          end
          MD_ACC: {hi_reg, lo_reg} <= acc_full;
          MD_DIV: begin
            if (div_done) begin
              hi_reg <= div_rem;
              lo_reg <= div_quo;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
